eth_mac_tx_gmii: RTL and testbench
==================================

// Module: eth_mac_tx_gmii
// PURPOSE
//  GMII transmit MAC, byte-wide. Takes one Ethernet frame per AXIS packet on axis_i (dest MAC through
//  payload, no FCS) and drives eth_txd/eth_txen/eth_txer. Adds preamble and SFD, zero-pads short frames,
//  appends the CRC-32 FCS and enforces the inter-frame gap. It is the transmit side of the RX MAC that
//  feeds the ARP/TCP test harnesses, and it sits between the ARP engine/TCP stack and the PHY.
// PARAMETERS
//  PREAMBLE_BYTES  7   count of 0x55 bytes before the SFD (0xD5)
//  MIN_FRAME_BYTES 60  minimum bytes before FCS; shorter frames get 0x00 padding up to it; 0 disables padding
//  IFG_BYTES       12  minimum cycles with eth_txen low after the last FCS byte
// PORTS
//  clk            in   1  single clock for all logic (125 MHz GMII TX clock)
//  aresetn        in   1  asynchronous active-low reset
//  axis_i_tready  out  1  AXIS sink ready
//  axis_i_tvalid  in   1  AXIS sink valid
//  axis_i_tdata   in   8  frame byte, first byte = dest MAC MSB
//  axis_i_tlast   in   1  marks the last frame byte
//  eth_txd        out  8  GMII transmit data
//  eth_txen       out  1  GMII transmit enable
//  eth_txer       out  1  GMII transmit error
// BEHAVIOUR
//  - Reset: state=IDLE; eth_txd=0x00, eth_txen=0, eth_txer=0, axis_i_tready=0; CRC, byte and IFG counters
//    cleared. Reset asserted mid-frame truncates the frame at once (txen drops asynchronously). No IFG is
//    owed after reset.
//  - eth_* outputs are registered. axis_i_tready is combinational from state only, never from tvalid.
//  - States: IDLE -> PREAMBLE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE.
//  - IDLE: txen=0. tvalid sampled high at edge N starts a frame: 0x55 is on the wire from edge N to N+1.
//    No byte is consumed in IDLE.
//  - PREAMBLE: PREAMBLE_BYTES cycles of 0x55, then one cycle of 0xD5 (SFD).
//  - tready: high during the SFD cycle and every DATA cycle until the beat with tlast is accepted.
//    A byte accepted at edge E is on eth_txd from edge E. The payload is contiguous with the SFD when
//    the source never stalls.
//  - Underrun: tready high and tvalid low at an edge -> next wire cycle is txen=1, txer=1, txd=0x00.
//    That cycle is excluded from the CRC and the byte count. The frame continues when data resumes.
//  - Byte count: 16 bits, counts payload+pad bytes, saturates at 0xFFFF. No maximum-length check.
//  - tlast accepted with count < MIN_FRAME_BYTES -> PAD: 0x00 bytes (CRC included) until count ==
//    MIN_FRAME_BYTES. Otherwise go straight to FCS.
//  - CRC-32: reflected, poly 0xEDB88320, init 0xFFFFFFFF, updated per wire byte of payload+pad.
//    FCS = ~crc, sent LSB byte first over 4 cycles with txen=1 and txer=0.
//  - IFG: txen=0, txd=0x00 for exactly IFG_BYTES cycles, then IDLE. If tvalid is already high on
//    entering IDLE, the next preamble starts on the following cycle. Back-to-back frames are therefore
//    separated by exactly IFG_BYTES idle cycles.
//  - tlast on the first payload byte is legal (1-byte frame, padded).
//  - tdata/tlast are ignored whenever tready=0.
//  - The source must not deassert tvalid mid-frame except as the underrun case above.
// TESTING
//  - Reset: check all outputs 0 and tready 0. Release reset: outputs stay 0 with tvalid low.
//  - MIN_FRAME_BYTES=0, send ASCII "123456789" with no stalls: wire shows 7x55, D5, 31..39,
//    then FCS 26 39 F4 CB; txen high for 21 cycles; txer never high.
//  - Default params, 14-byte frame: 46 bytes of 0x00 pad follow. 60 bytes reach the CRC. FCS matches a
//    software model. Total txen-high time is 72 cycles.
//  - Two 64-byte frames back to back with tvalid always high: exactly 12 txen-low cycles between the
//    last FCS byte and the next 0x55. tready is low throughout FCS and IFG.
//  - Drop tvalid for 2 cycles mid-payload: two txen=1/txer=1 cycles with txd=0x00. FCS equals the FCS
//    of the same frame sent without stalls.
//  - Assert aresetn low during byte 20 of a frame: txen goes to 0 immediately. After release, a new
//    frame starts with the full preamble and a correct FCS, with no IFG wait.

Source files
------------

// File: rtl/eth_mac_tx_gmii_if.sv
// rtl/eth_mac_tx_gmii_if.sv - byte-wide frame stream carrying one Ethernet frame per packet
//
// Signals:
//   tvalid  source has a byte on tdata
//   tready  sink accepts the byte at the next clock edge
//   tdata   frame byte (first byte = destination MAC MSB)
//   tlast   marks the last byte of the frame
// Modports: master = frame source, slave = frame sink (the MAC).
interface eth_mac_tx_gmii_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/eth_mac_tx_gmii.sv
// rtl/eth_mac_tx_gmii.sv - GMII transmit MAC with preamble/SFD, padding, CRC-32 FCS and IFG
//
// eth_crc32_byte: combinational one-byte step of the reflected Ethernet CRC-32.
//   crc_in   running CRC before the byte
//   data     wire byte
//   crc_out  running CRC after the byte
//
// eth_mac_tx_gmii: frame stream in, GMII out.
//   clk       GMII transmit clock (125 MHz)
//   aresetn   asynchronous active-low reset
//   axis_i    frame stream sink (tvalid/tready/tdata/tlast)
//   eth_txd   GMII transmit data (registered)
//   eth_txen  GMII transmit enable (registered)
//   eth_txer  GMII transmit error (registered)
module eth_crc32_byte (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end
endmodule

module eth_mac_tx_gmii #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic             clk,
    input  logic             aresetn,
    eth_mac_tx_gmii_if.slave axis_i,
    output logic [7:0]       eth_txd,
    output logic             eth_txen,
    output logic             eth_txer
);
    localparam logic [7:0]  PRE_W = 8'(PREAMBLE_BYTES);
    localparam logic [7:0]  IFG_W = 8'(IFG_BYTES);
    localparam logic [15:0] MIN_W = 16'(MIN_FRAME_BYTES);

    // State names the byte that the next clock edge puts on the wire, so DATA
    // (tready high) covers the SFD wire cycle and every payload wire cycle.
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [15:0] byte_cnt, byte_cnt_nxt, byte_cnt_inc;
    logic [31:0] crc, crc_nxt, crc_upd, fcs;
    logic [7:0]  crc_byte;
    logic [7:0]  txd_nxt;
    logic        txen_nxt, txer_nxt;
    logic [7:0]  cnt_inc;

    assign axis_i.tready = (state == S_DATA);

    assign crc_byte     = (state == S_PAD) ? 8'h00 : axis_i.tdata;
    assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign cnt_inc      = cnt + 8'd1;
    assign fcs          = ~crc;

    eth_crc32_byte u_crc (
        .crc_in  (crc),
        .data    (crc_byte),
        .crc_out (crc_upd)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            byte_cnt <= 16'd0;
            crc      <= 32'hFFFF_FFFF;
            eth_txd  <= 8'h00;
            eth_txen <= 1'b0;
            eth_txer <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            crc      <= crc_nxt;
            eth_txd  <= txd_nxt;
            eth_txen <= txen_nxt;
            eth_txer <= txer_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        byte_cnt_nxt = byte_cnt;
        crc_nxt      = crc;
        txd_nxt      = 8'h00;
        txen_nxt     = 1'b0;
        txer_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                // First preamble byte goes out on the same edge that sees tvalid.
                if (axis_i.tvalid) begin
                    txd_nxt      = 8'h55;
                    txen_nxt     = 1'b1;
                    cnt_nxt      = 8'd1;
                    crc_nxt      = 32'hFFFF_FFFF;
                    byte_cnt_nxt = 16'd0;
                    state_nxt    = (PRE_W > 8'd1) ? S_PREAMBLE : S_SFD;
                end
            end
            S_PREAMBLE: begin
                txd_nxt  = 8'h55;
                txen_nxt = 1'b1;
                cnt_nxt  = cnt_inc;
                if (cnt_inc >= PRE_W) begin
                    state_nxt = S_SFD;
                end
            end
            S_SFD: begin
                txd_nxt   = 8'hD5;
                txen_nxt  = 1'b1;
                state_nxt = S_DATA;
            end
            S_DATA: begin
                txen_nxt = 1'b1;
                if (axis_i.tvalid) begin
                    txd_nxt      = axis_i.tdata;
                    crc_nxt      = crc_upd;
                    byte_cnt_nxt = byte_cnt_inc;
                    if (axis_i.tlast) begin
                        cnt_nxt   = 8'd0;
                        state_nxt = (byte_cnt_inc < MIN_W) ? S_PAD : S_FCS;
                    end
                end else begin
                    // Underrun: flag the cycle, keep it out of CRC and count.
                    txer_nxt = 1'b1;
                end
            end
            S_PAD: begin
                txen_nxt     = 1'b1;
                crc_nxt      = crc_upd;
                byte_cnt_nxt = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_W) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_FCS;
                end
            end
            S_FCS: begin
                txen_nxt = 1'b1;
                case (cnt[1:0])
                    2'd0:    txd_nxt = fcs[7:0];
                    2'd1:    txd_nxt = fcs[15:8];
                    2'd2:    txd_nxt = fcs[23:16];
                    default: txd_nxt = fcs[31:24];
                endcase
                cnt_nxt = cnt_inc;
                if (cnt[1:0] == 2'd3) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = (IFG_W == 8'd0) ? S_IDLE : S_IFG;
                end
            end
            S_IFG: begin
                // IFG_BYTES low cycles here; IDLE then launches the next preamble.
                cnt_nxt = cnt_inc;
                if (cnt_inc >= IFG_W) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_eth_mac_tx_gmii.sv
// tb/tb_eth_mac_tx_gmii.sv - directed self-checking bench for eth_mac_tx_gmii
module tb_eth_mac_tx_gmii;
    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       sel = 1'b0;
    logic       tvalid = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tlast = 1'b0;

    logic [7:0] txd0, txd1;
    logic       txen0, txen1, txer0, txer1;

    eth_mac_tx_gmii_if if0 ();
    eth_mac_tx_gmii_if if1 ();

    assign if0.tvalid = tvalid & ~sel;
    assign if0.tdata  = tdata;
    assign if0.tlast  = tlast;
    assign if1.tvalid = tvalid & sel;
    assign if1.tdata  = tdata;
    assign if1.tlast  = tlast;

    eth_mac_tx_gmii #(.MIN_FRAME_BYTES(0)) dut0 (
        .clk(clk), .aresetn(aresetn), .axis_i(if0),
        .eth_txd(txd0), .eth_txen(txen0), .eth_txer(txer0)
    );

    eth_mac_tx_gmii dut1 (
        .clk(clk), .aresetn(aresetn), .axis_i(if1),
        .eth_txd(txd1), .eth_txen(txen1), .eth_txer(txer1)
    );

    always #4 clk = ~clk;

    wire       tr     = sel ? if1.tready : if0.tready;
    wire [7:0] m_txd  = sel ? txd1 : txd0;
    wire       m_txen = sel ? txen1 : txen0;
    wire       m_txer = sel ? txer1 : txer0;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] log_q[$];
    logic [7:0]  fb[$];
    logic [7:0]  body_q[$];
    logic [7:0]  wire_q[$];
    int          txer_cnt, bad_txer, first_txer;

    always @(negedge clk) log_q.push_back({tr, m_txer, m_txen, m_txd});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fcs_model();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (body_q[k]) begin
            c = c ^ {24'h0, body_q[k]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic send(input int stall_at, input int stall_len, input int abort_at);
        int  i, guard, sl;
        bit  done;
        i = 0; guard = 0; sl = stall_len; done = 1'b0;
        while (!done && i < fb.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (tr && i == stall_at && sl > 0) begin
                tvalid = 1'b0;
                sl--;
            end else begin
                tvalid = 1'b1;
                tdata  = fb[i];
                tlast  = (i == fb.size() - 1);
                if (tr) begin
                    i++;
                    if (i == abort_at) done = 1'b1;
                end
            end
        end
        if (!done) chk("send_accepted", i, fb.size());
    endtask

    task automatic idle_wait(input int n);
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic find_burst(input int from, output int s, output int e);
        s = -1; e = -1;
        wire_q.delete();
        txer_cnt = 0; bad_txer = 0; first_txer = -1;
        for (int k = from; k < log_q.size(); k++) begin
            if (log_q[k][8] && s < 0) s = k;
            if (s >= 0) begin
                if (!log_q[k][8]) begin
                    e = k;
                    break;
                end
                if (log_q[k][9]) begin
                    if (first_txer < 0) first_txer = k - s;
                    txer_cnt++;
                    if (log_q[k][7:0] != 8'h00) bad_txer++;
                end else begin
                    wire_q.push_back(log_q[k][7:0]);
                end
            end
        end
        if (e < 0) e = log_q.size();
    endtask

    task automatic check_frame(input string tag, input int from, input int pad_to,
                               input int exp_txer, output int s, output int e);
        logic [7:0]  exp_q[$];
        logic [31:0] f, got_fcs;
        int          bad, n;
        body_q = fb;
        while (body_q.size() < pad_to) body_q.push_back(8'h00);
        f = fcs_model();
        exp_q = {};
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body_q[k]) exp_q.push_back(body_q[k]);
        exp_q.push_back(f[7:0]);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[31:24]);
        find_burst(from, s, e);
        bad = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= wire_q.size() || wire_q[k] !== exp_q[k]) bad++;
        chk({tag, "_bytes"}, bad, 0);
        chk({tag, "_nbytes"}, wire_q.size(), exp_q.size());
        chk({tag, "_txer"}, txer_cnt, exp_txer);
        chk({tag, "_txer_txd"}, bad_txer, 0);
        n = wire_q.size();
        got_fcs = (n >= 4) ? {wire_q[n-1], wire_q[n-2], wire_q[n-3], wire_q[n-4]} : 32'h0;
        chk({tag, "_fcs"}, got_fcs, f);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e, s1, e1, s2, e2, hi;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_txen1", txen1, 0);
        chk("rst_txer1", txer1, 0);
        chk("rst_txd1", txd1, 0);
        chk("rst_tready1", if1.tready, 0);
        chk("rst_txen0", txen0, 0);
        chk("rst_tready0", if0.tready, 0);
        aresetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_txen", txen1, 0);
        chk("post_rst_txd", txd1, 0);
        chk("post_rst_tready", if1.tready, 0);

        // "123456789", no padding
        sel = 1'b0;
        @(negedge clk); #1; log_q.delete();
        fb = {};
        for (int k = 0; k < 9; k++) fb.push_back(8'(8'h31 + k));
        send(-1, 0, -1);
        idle_wait(40);
        check_frame("t2", 0, 0, 0, s, e);
        chk("t2_txen_cycles", e - s, 21);
        chk("t2_fcs_const", {wire_q[20], wire_q[19], wire_q[18], wire_q[17]}, 32'hCBF4_3926);

        // 14-byte frame, padded to 60
        sel = 1'b1;
        @(negedge clk); #1; log_q.delete();
        fb = {};
        for (int k = 0; k < 14; k++) fb.push_back(8'(8'hA0 + 3 * k));
        send(-1, 0, -1);
        idle_wait(100);
        check_frame("t3", 0, 60, 0, s, e);
        chk("t3_txen_cycles", e - s, 72);

        // Two 64-byte frames back to back
        @(negedge clk); #1; log_q.delete();
        fb = {};
        for (int k = 0; k < 64; k++) fb.push_back(8'(k * 7 + 1));
        send(-1, 0, -1);
        send(-1, 0, -1);
        idle_wait(40);
        check_frame("t4a", 0, 60, 0, s1, e1);
        check_frame("t4b", e1, 60, 0, s2, e2);
        chk("t4a_txen_cycles", e1 - s1, 76);
        chk("t4b_txen_cycles", e2 - s2, 76);
        chk("t4_gap", s2 - e1, 12);
        hi = 0;
        for (int k = e1 - 4; k < s2; k++) if (k >= 0 && log_q[k][10]) hi++;
        chk("t4_tready_fcs_ifg", hi, 0);
        chk("t4_tready_sfd", log_q[s1 + 7][10], 1);

        // Two-cycle underrun mid-payload
        @(negedge clk); #1; log_q.delete();
        fb = {};
        for (int k = 0; k < 20; k++) fb.push_back(8'(8'hF0 - 5 * k));
        send(10, 2, -1);
        idle_wait(100);
        check_frame("t5", 0, 60, 2, s, e);
        chk("t5_txen_cycles", e - s, 74);
        chk("t5_first_txer", first_txer, 18);

        // Reset during byte 20, then a clean frame
        fb = {};
        for (int k = 0; k < 30; k++) fb.push_back(8'(8'h40 + k));
        send(-1, 0, 21);
        @(posedge clk); #2;
        chk("t6_byte20_txd", m_txd, fb[20]);
        chk("t6_byte20_txen", m_txen, 1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_txen", m_txen, 0);
        chk("t6_rst_txd", m_txd, 0);
        chk("t6_rst_tready", tr, 0);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1; log_q.delete();
        fb = {};
        for (int k = 0; k < 14; k++) fb.push_back(8'(8'h11 * (k + 1)));
        send(-1, 0, -1);
        idle_wait(100);
        check_frame("t6", 0, 60, 0, s, e);
        chk("t6_start", s, 1);
        chk("t6_txen_cycles", e - s, 72);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
